// File: rtl/spc_sym.sv
// rtl/spc_sym.sv - serial-to-parallel symbol converter with frame-start realignment
module spc_sym #(
   parameter int WIDTH     = 2,
   parameter bit MSB_FIRST = 1'b1,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             din,
   input  logic             sync,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             out_ready,
   output logic             overflow,
   input  logic             ovf_clr,
   output logic [CNT_W-1:0] word_cnt
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

   logic [BW-1:0]    bcnt;
   logic [BW-1:0]    slot;
   logic [BW-1:0]    pos;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] word_next;
   logic             complete;
   logic             drop;
   logic             load;

   // sync restarts the word, so its bit lands in the first-received slot
   always_comb begin
      slot = sync ? '0 : bcnt;
      pos  = MSB_FIRST ? (LAST - slot) : slot;
   end

   // merge the incoming bit into the partial word; sync discards what was collected
   always_comb begin
      word_next      = sync ? '0 : sreg;
      word_next[pos] = din;
   end

   // a word completes on its last bit, unless that bit is a frame start
   always_comb begin
      complete = en & ~sync & (bcnt == LAST);
      drop     = complete & dout_valid & ~out_ready;
      load     = complete & ~drop;
   end

   // bit collection: shift register and bit counter advance only on en
   always_ff @(posedge clk) begin
      if (reset) begin
         bcnt <= '0;
         sreg <= '0;
      end else if (en) begin
         sreg <= word_next;
         if (sync)
            bcnt <= BW'(1);
         else if (complete)
            bcnt <= '0;
         else
            bcnt <= bcnt + BW'(1);
      end
   end

   // output register and valid/ready handshake; a held word is never overwritten
   always_ff @(posedge clk) begin
      if (reset) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (load) begin
         dout       <= word_next;
         dout_valid <= 1'b1;
      end else if (dout_valid && out_ready) begin
         dout_valid <= 1'b0;
      end
   end

   // sticky overflow; a new drop wins over a simultaneous clear
   always_ff @(posedge clk) begin
      if (reset)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
      else if (ovf_clr)
         overflow <= 1'b0;
   end

   // saturating count of completed words (dropped ones included) since frame start
   always_ff @(posedge clk) begin
      if (reset)
         word_cnt <= '0;
      else if (en && sync)
         word_cnt <= '0;
      else if (complete && (word_cnt != {CNT_W{1'b1}}))
         word_cnt <= word_cnt + CNT_W'(1);
   end

endmodule
